// File: rtl/nodf_module_intf_if.sv
// Control-signal bundle of one ap_ctrl_hs block.
//
// Handshake: ap_start requests a transaction and is consumed when the
// block is idle; ap_ready marks the cycle its inputs are taken; ap_done
// marks completion and is held until ap_continue is high in the same
// cycle, which is the cycle the result is accepted.
//
// The master modport drives the signals (the block and its controller,
// or a testbench standing in for them). The slave modport only observes.
interface nodf_module_intf_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
  modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);
endinterface

// File: rtl/nodf_module_intf.sv
// Passive status monitor for one ap_ctrl_hs block: counts transactions,
// measures latency and begin-to-begin interval, flags protocol misuse and
// freezes once the run-level finish flag is seen. All outputs are
// registered and reflect the previous cycle.
module nodf_module_intf #(
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  nodf_module_intf_if.slave    ctrl,
  input  logic                 finish,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     start_count,
  output logic [CNT_W-1:0]     ready_count,
  output logic [CNT_W-1:0]     done_count,
  output logic [CNT_W-1:0]     busy_cycles,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     last_latency,
  output logic [CNT_W-1:0]     min_latency,
  output logic [CNT_W-1:0]     max_latency,
  output logic [CNT_W-1:0]     last_interval,
  output logic                 txn_done,
  output logic                 protocol_error
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACTIVE    = 2'd1,
    S_DONE_WAIT = 2'd2,
    S_FINISHED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_next;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] begin_cyc;
  logic             have_begin;

  logic             begin_evt;
  logic             accept_evt;
  logic             busy_evt;
  logic             stall_evt;
  logic             err_evt;
  logic [CNT_W-1:0] start_after;
  logic [CNT_W-1:0] span;
  logic [CNT_W-1:0] latency;

  // Every counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ALL_ONES) ? v : v + ONE;
  endfunction

  assign state = state_q;

  // Classify this cycle's events and choose the next state; a begin from
  // IDLE also evaluates done in the same cycle so latency can be 1.
  always_comb begin
    state_next = state_q;
    begin_evt  = 1'b0;
    accept_evt = 1'b0;
    busy_evt   = 1'b0;
    stall_evt  = 1'b0;
    err_evt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl.ap_start) begin
          begin_evt = 1'b1;
          busy_evt  = 1'b1;
          if (ctrl.ap_done && ctrl.ap_continue) begin
            accept_evt = 1'b1;
            state_next = S_IDLE;
          end else if (ctrl.ap_done) begin
            state_next = S_DONE_WAIT;
          end else begin
            state_next = S_ACTIVE;
          end
        end else begin
          // Done or ready without an outstanding start is misuse.
          if (ctrl.ap_done || ctrl.ap_ready) err_evt = 1'b1;
        end
      end
      S_ACTIVE: begin
        busy_evt = 1'b1;
        if (ctrl.ap_done) begin
          if (ctrl.ap_continue) begin
            accept_evt = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_DONE_WAIT;
          end
        end
      end
      S_DONE_WAIT: begin
        busy_evt  = 1'b1;
        stall_evt = 1'b1;
        if (ctrl.ap_continue) begin
          accept_evt = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_FINISHED;
      end
    endcase

    start_after = begin_evt ? sat_inc(start_count) : start_count;
    // A completion must never push done_count past start_count.
    if (accept_evt && (done_count >= start_after) && (done_count != ALL_ONES)) err_evt = 1'b1;

    span    = cyc - (begin_evt ? cyc : begin_cyc);
    latency = (span == ALL_ONES) ? span : span + ONE;

    // finish wins over any other transition; this cycle's events still count.
    if (finish) state_next = S_FINISHED;
  end

  // State register plus all counters and statistics, frozen once FINISHED.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cyc            <= '0;
      begin_cyc      <= '0;
      have_begin     <= 1'b0;
      start_count    <= '0;
      ready_count    <= '0;
      done_count     <= '0;
      busy_cycles    <= '0;
      stall_cycles   <= '0;
      last_latency   <= '0;
      min_latency    <= ALL_ONES;
      max_latency    <= '0;
      last_interval  <= '0;
      txn_done       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state_q  <= state_next;
      cyc      <= sat_inc(cyc);
      txn_done <= accept_evt;
      if (err_evt) protocol_error <= 1'b1;
      if (state_q != S_FINISHED) begin
        if (ctrl.ap_ready) ready_count <= sat_inc(ready_count);
        if (busy_evt) busy_cycles <= sat_inc(busy_cycles);
        if (stall_evt) stall_cycles <= sat_inc(stall_cycles);
        if (begin_evt) begin
          start_count <= start_after;
          begin_cyc   <= cyc;
          have_begin  <= 1'b1;
          if (have_begin) last_interval <= cyc - begin_cyc;
        end
        if (accept_evt) begin
          done_count   <= sat_inc(done_count);
          last_latency <= latency;
          if (latency < min_latency) min_latency <= latency;
          if (latency > max_latency) max_latency <= latency;
        end
      end
    end
  end

endmodule

// File: tb/tb_nodf_module_intf.sv
// Bench for nodf_module_intf: directed scenarios plus randomized
// transactions, each described by a plan (idle gap, work length, stall
// length). The reference model derives counts and statistics straight
// from the plan; completions are queued and checked when txn_done fires.
module tb_nodf_module_intf;
  localparam int CNT_W = 32;
  localparam int W     = 5 * CNT_W;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic finish = 1'b0;

  nodf_module_intf_if bus ();

  logic [1:0]       state;
  logic [CNT_W-1:0] start_count, ready_count, done_count, busy_cycles, stall_cycles;
  logic [CNT_W-1:0] last_latency, min_latency, max_latency, last_interval;
  logic             txn_done, protocol_error;

  nodf_module_intf #(.CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl           (bus.slave),
    .finish         (finish),
    .state          (state),
    .start_count    (start_count),
    .ready_count    (ready_count),
    .done_count     (done_count),
    .busy_cycles    (busy_cycles),
    .stall_cycles   (stall_cycles),
    .last_latency   (last_latency),
    .min_latency    (min_latency),
    .max_latency    (max_latency),
    .last_interval  (last_interval),
    .txn_done       (txn_done),
    .protocol_error (protocol_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int tb_cyc = 0;

  // Scoreboard: {done_count, last_latency, min_latency, max_latency, last_interval}
  logic [W-1:0] exp_q[$];

  // Reference model state
  int m_start, m_done, m_busy, m_stall, m_ready;
  int m_last, m_min, m_max, m_int, m_prev_begin;
  bit m_has_begin;

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, tb_cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    tb_cyc++;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.ap_start    = 1'b0;
    bus.ap_ready    = 1'b0;
    bus.ap_done     = 1'b0;
    bus.ap_continue = 1'b1;
  endtask

  task automatic model_reset();
    m_start = 0; m_done = 0; m_busy = 0; m_stall = 0; m_ready = 0;
    m_last = 0; m_min = -1; m_max = 0; m_int = 0; m_prev_begin = 0;
    m_has_begin = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    finish = 1'b0;
    idle_inputs();
    repeat (2) step();
    reset  = 1'b0;
    tb_cyc = 0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " state"},          CNT_W'(state), CNT_W'(0));
    chk({tag, " start_count"},    start_count, '0);
    chk({tag, " ready_count"},    ready_count, '0);
    chk({tag, " done_count"},     done_count, '0);
    chk({tag, " busy_cycles"},    busy_cycles, '0);
    chk({tag, " stall_cycles"},   stall_cycles, '0);
    chk({tag, " last_latency"},   last_latency, '0);
    chk({tag, " min_latency"},    min_latency, {CNT_W{1'b1}});
    chk({tag, " max_latency"},    max_latency, '0);
    chk({tag, " last_interval"},  last_interval, '0);
    chk({tag, " txn_done"},       CNT_W'(txn_done), CNT_W'(0));
    chk({tag, " protocol_error"}, CNT_W'(protocol_error), CNT_W'(0));
  endtask

  task automatic check_totals(input string tag);
    chk({tag, " start_count"},  start_count,  CNT_W'(m_start));
    chk({tag, " done_count"},   done_count,   CNT_W'(m_done));
    chk({tag, " busy_cycles"},  busy_cycles,  CNT_W'(m_busy));
    chk({tag, " stall_cycles"}, stall_cycles, CNT_W'(m_stall));
    chk({tag, " ready_count"},  ready_count,  CNT_W'(m_ready));
  endtask

  // ---------------- driver ----------------
  // One transaction: 'gap' idle cycles, a begin, done first raised 'work'
  // cycles after the begin (inclusive), then 's' cycles held off by
  // ap_continue=0. Latency is therefore work + s.
  task automatic run_txn(input int gap, input int work, input int s,
                         input bit hold_start, input bit rand_side);
    int total;
    int lat;
    int exp_st;
    total = work + s;
    for (int g = 0; g < gap; g++) begin
      idle_inputs();
      step();
    end
    m_start++;
    if (m_has_begin) m_int = tb_cyc - m_prev_begin;
    m_prev_begin = tb_cyc;
    m_has_begin  = 1'b1;
    for (int i = 0; i < total; i++) begin
      bus.ap_start = (i == 0) || hold_start || (rand_side && ($urandom_range(0, 1) == 1));
      bus.ap_ready = (i == 0) || (rand_side && ($urandom_range(0, 3) == 0));
      bus.ap_done  = (i >= work - 1);
      if (i < work - 1)
        bus.ap_continue = rand_side ? ($urandom_range(0, 1) == 1) : 1'b1;
      else
        bus.ap_continue = (i == total - 1);
      if (bus.ap_ready) m_ready++;
      m_busy++;
      if (i >= work) m_stall++;
      if (i == total - 1) begin
        lat = total;
        m_done++;
        m_last = lat;
        if ($unsigned(lat) < $unsigned(m_min)) m_min = lat;
        if (lat > m_max) m_max = lat;
        exp_q.push_back({CNT_W'(m_done), CNT_W'(m_last), CNT_W'(m_min), CNT_W'(m_max), CNT_W'(m_int)});
      end
      step();
      exp_st = (i == total - 1) ? 0 : ((i >= work - 1) ? 2 : 1);
      chk("txn state", CNT_W'(state), CNT_W'(exp_st));
    end
    idle_inputs();
  endtask

  // ---------------- monitor ----------------
  // Pops one expected record per txn_done pulse.
  always @(negedge clock) begin
    logic [W-1:0] rec;
    if (!reset && txn_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL txn_done unexpected: got pulse expected none (cyc %0d)", tb_cyc);
      end else begin
        rec = exp_q.pop_front();
        chk("mon done_count",    done_count,    rec[4*CNT_W +: CNT_W]);
        chk("mon last_latency",  last_latency,  rec[3*CNT_W +: CNT_W]);
        chk("mon min_latency",   min_latency,   rec[2*CNT_W +: CNT_W]);
        chk("mon max_latency",   max_latency,   rec[1*CNT_W +: CNT_W]);
        chk("mon last_interval", last_interval, rec[0 +: CNT_W]);
      end
    end
  end

  task automatic drain_check(input string tag);
    step();
    chk({tag, " pending completions"}, CNT_W'(exp_q.size()), CNT_W'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Single transaction: begin at cyc 5, done at cyc 14
    run_txn(5, 10, 0, 1'b0, 1'b0);
    drain_check("single");
    check_totals("single");
    chk("single last_latency", last_latency, CNT_W'(10));
    chk("single protocol_error", CNT_W'(protocol_error), CNT_W'(0));

    // Back-to-back with ap_start held: begins at 0 and 5
    do_reset();
    run_txn(0, 5, 0, 1'b1, 1'b0);
    run_txn(0, 5, 0, 1'b1, 1'b0);
    drain_check("b2b");
    chk("b2b last_interval", last_interval, CNT_W'(5));
    chk("b2b done_count", done_count, CNT_W'(2));
    // Minimum latency: start and done together from IDLE
    run_txn(2, 1, 0, 1'b0, 1'b0);
    drain_check("minlat");
    chk("minlat min_latency", min_latency, CNT_W'(1));
    check_totals("b2b");

    // Stall: done at cyc 8, ap_continue low until cyc 11
    do_reset();
    run_txn(0, 9, 3, 1'b0, 1'b0);
    drain_check("stall");
    chk("stall stall_cycles", stall_cycles, CNT_W'(3));
    chk("stall last_latency", last_latency, CNT_W'(12));
    check_totals("stall");

    // Randomized transactions
    do_reset();
    for (int t = 0; t < 40; t++)
      run_txn($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 3), 1'b0, 1'b1);
    drain_check("rand");
    check_totals("rand");
    chk("rand min_latency", min_latency, CNT_W'(m_min));
    chk("rand max_latency", max_latency, CNT_W'(m_max));
    chk("rand protocol_error", CNT_W'(protocol_error), CNT_W'(0));

    // Finish freeze: begin at 0, finish at cyc 20, done at cyc 25
    do_reset();
    bus.ap_start = 1'b1;
    step();
    bus.ap_start = 1'b0;
    repeat (19) step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("finish state", CNT_W'(state), CNT_W'(3));
    bus.ap_ready = 1'b1;
    repeat (4) step();
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b1;
    step();
    bus.ap_done  = 1'b0;
    step();
    chk("finish state held", CNT_W'(state), CNT_W'(3));
    chk("finish done_count", done_count, CNT_W'(0));
    chk("finish start_count", start_count, CNT_W'(1));
    chk("finish busy_cycles", busy_cycles, CNT_W'(21));
    chk("finish ready_count", ready_count, CNT_W'(0));
    chk("finish protocol_error", CNT_W'(protocol_error), CNT_W'(0));

    // Protocol error: ap_done while IDLE, sticky until reset
    do_reset();
    bus.ap_done = 1'b1;
    step();
    bus.ap_done = 1'b0;
    chk("perr done set", CNT_W'(protocol_error), CNT_W'(1));
    repeat (3) step();
    chk("perr done held", CNT_W'(protocol_error), CNT_W'(1));
    chk("perr state", CNT_W'(state), CNT_W'(0));
    do_reset();
    chk("perr cleared", CNT_W'(protocol_error), CNT_W'(0));
    // Protocol error: ap_ready while IDLE without ap_start
    bus.ap_ready = 1'b1;
    step();
    bus.ap_ready = 1'b0;
    chk("perr ready set", CNT_W'(protocol_error), CNT_W'(1));
    chk("perr ready_count", ready_count, CNT_W'(1));

    // Reset mid-operation at cyc 6 of a transaction
    do_reset();
    bus.ap_start = 1'b1;
    step();
    bus.ap_start = 1'b0;
    repeat (5) step();
    chk("midrst active", CNT_W'(state), CNT_W'(1));
    chk("midrst busy", busy_cycles, CNT_W'(6));
    reset = 1'b1;
    step();
    reset = 1'b0;
    tb_cyc = 0;
    model_reset();
    check_reset_vals("midrst");
    run_txn(0, 3, 0, 1'b0, 1'b0);
    drain_check("after midrst");
    check_totals("after midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nodf_module_intf.md
# nodf_module_intf

Hardware status monitor for one non-dataflow HLS block using the ap_ctrl_hs handshake (ap_start / ap_ready / ap_done / ap_continue). It sits beside the monitored block in simulation or debug builds, observes its control signals without driving them, and tracks per-transaction status. It exposes transaction counts, latency and interval statistics, and a state indication, and freezes everything when the run-level `finish` flag rises.

## Interface
- `CNT_W`, default 32: width of every counter and statistic output.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  monitored block start request.
- `ap_ready`  in  1  monitored block ready (inputs consumed).
- `ap_done`  in  1  monitored block done.
- `ap_continue`  in  1  downstream accept of done; tie 1 when unused.
- `finish`  in  1  end-of-run flag; freezes the monitor.
- `state`  out  2  0=IDLE, 1=ACTIVE, 2=DONE_WAIT, 3=FINISHED.
- `start_count`  out  CNT_W  transactions begun.
- `ready_count`  out  CNT_W  cycles with ap_ready=1 while not FINISHED.
- `done_count`  out  CNT_W  transactions completed (done accepted).
- `busy_cycles`  out  CNT_W  cycles spent in ACTIVE or DONE_WAIT.
- `stall_cycles`  out  CNT_W  cycles spent in DONE_WAIT.
- `last_latency`, `min_latency`, `max_latency`  out  CNT_W  latency statistics.
- `last_interval`  out  CNT_W  cycles between the last two transaction begins.
- `txn_done`  out  1  one-cycle pulse on each completed transaction.
- `protocol_error`  out  1  sticky error flag.

## Operation
- A free-running cycle counter `cyc` is 0 in the first cycle after reset deasserts and increments each cycle. It saturates and is internal only.
- **IDLE:** if `ap_start=1`, a begin is recorded (`begin_cyc=cyc`), `start_count` increments, and the state goes to ACTIVE. If this is not the first begin, `last_interval = cyc - prev_begin_cyc`.
- **ACTIVE:**
  - `ap_done=1` and `ap_continue=1`: the transaction completes.
  - `ap_done=1` and `ap_continue=0`: go to DONE_WAIT.
- **DONE_WAIT:** `stall_cycles` increments each cycle. The state holds until `ap_continue=1`; the transaction completes in that cycle.
- **Completion:**
  - `latency = cyc - begin_cyc + 1`, where `cyc` is the cycle in which done is accepted.
  - `last_latency` is updated; `min_latency` and `max_latency` are updated with the new value; `done_count` increments.
  - `txn_done` pulses in the following cycle.
  - The state returns to IDLE. A new begin is only recognised from IDLE, so `ap_start` held high through done begins the next transaction one cycle after completion.
- **`ap_ready`:** counted whenever high and the state is not FINISHED. It does not gate begin.
- **`protocol_error`** is set and held until reset on any of:
  - `ap_done=1` while IDLE;
  - `ap_ready=1` while IDLE with `ap_start=0`;
  - `done_count` about to exceed `start_count`.
- **`finish=1`:** any event in that same cycle is still recorded. From the next cycle the state is FINISHED and all counters and statistics freeze until reset. `finish` has priority over every other transition.
- All counters saturate at all-ones; they never wrap.

## Timing
- Reset values:
  - `state=IDLE`; all counts, `busy_cycles`, `stall_cycles`, `last_latency`, `max_latency` and `last_interval` are 0.
  - `min_latency` = all-ones.
  - `txn_done=0`, `protocol_error=0`.
- Outputs are registered; each one reflects the events of the previous cycle.
- Reset asserted mid-transaction aborts it immediately; statistics from that transaction are discarded.
- The minimum latency is 1, when `ap_start` and `ap_done` are high in the same cycle from IDLE. Done is evaluated in that same cycle as the begin, as if the state were already ACTIVE.
- `busy_cycles` includes the begin cycle and the done-accept cycle.

## Test plan
- **Single transaction:** reset, then `ap_start=1` at cyc 5 (and `ap_ready=1` at cyc 5), `ap_done=1` at cyc 14 → `start_count=1`, `done_count=1`, `last_latency=min_latency=max_latency=10`, `busy_cycles=10`, `txn_done` pulse at cyc 15, `state=IDLE`.
- **Back-to-back:** `ap_start` held high; done at cyc 4 and at cyc 9 (begins at 0 and 5) → second `last_latency=5`, `last_interval=5`, `done_count=2`.
- **Stall:** done at cyc 8 with `ap_continue=0` until cyc 11 → `state=DONE_WAIT` from cyc 9, `stall_cycles=3`, `last_latency=12` for a begin at cyc 0.
- **Finish freeze:** `finish=1` at cyc 20 during ACTIVE → `state=FINISHED` at cyc 21; `ap_done` at cyc 25 leaves `done_count` unchanged.
- **Protocol error:** `ap_done=1` while IDLE → `protocol_error=1`, held after `ap_done` drops, cleared only by reset.
- **Reset mid-operation:** reset at cyc 6 of an active transaction → all outputs return to reset values on the next cycle.
